// File: rtl/camera_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : camera_ctrl
// Description : Exposure/readout controller for a two-row pixel array.
//               It owns the exposure value, which the Exp_increase and
//               Exp_decrease buttons adjust while idle. On Init it loads
//               the value onto Initial, pulses Start to the exposure timer,
//               waits for TF and then runs a fixed six-step, two-row readout.
// Ports       : Clk, Reset (sync, active-high)
//               Init, Exp_increase, Exp_decrease, TF         - inputs
//               Start, Initial[EXP_WIDTH], Erase, Expose,
//               NRE_1, NRE_2 (active-low), ADC, Busy         - outputs
//               Err (only with CAMERA_CTRL_TIMEOUT_EN)       - output
// Options     : CAMERA_CTRL_TIMEOUT_EN - adds an EXPOSE watchdog of
//               TO_CYCLES cycles; expiry returns to IDLE and sets Err.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_ctrl #(
    parameter int EXP_WIDTH = 5,
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int EXP_RESET = 16,
    parameter int TO_CYCLES = 34
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Init,
    input  logic                 Exp_increase,
    input  logic                 Exp_decrease,
    input  logic                 TF,
    output logic                 Start,
    output logic [EXP_WIDTH-1:0] Initial,
    output logic                 Erase,
    output logic                 Expose,
    output logic                 NRE_1,
    output logic                 NRE_2,
    output logic                 ADC,
    output logic                 Busy
`ifdef CAMERA_CTRL_TIMEOUT_EN
    ,
    output logic                 Err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_EXPOSE  = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    localparam logic [EXP_WIDTH-1:0] c_EXP_MIN   = EXP_WIDTH'(EXP_MIN);
    localparam logic [EXP_WIDTH-1:0] c_EXP_MAX   = EXP_WIDTH'(EXP_MAX);
    localparam logic [EXP_WIDTH-1:0] c_EXP_RESET = EXP_WIDTH'(EXP_RESET);
    localparam logic [2:0]           c_STEP_LAST = 3'd5;
    localparam logic [2:0]           c_STEP_ROW2 = 3'd3;

    // Elaboration-time sanity check of the parameter set.
    generate
        if ((EXP_MIN > EXP_MAX) || (EXP_RESET < EXP_MIN) || (EXP_RESET > EXP_MAX) ||
            (EXP_MAX >= (1 << EXP_WIDTH)) || (TO_CYCLES < 1)) begin : g_bad_params
            $error("camera_ctrl: inconsistent parameter set");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [2:0]             r_step;
    logic [2:0]             w_step_nx;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [EXP_WIDTH-1:0]   w_exp_nx;

    logic r_start, r_erase, r_expose, r_nre1, r_nre2, r_adc, r_busy;
    logic w_start, w_erase, w_expose, w_nre1, w_nre2, w_adc, w_busy;

`ifdef CAMERA_CTRL_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TO_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TO_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_cnt_nx;
    logic              r_err;
    logic              w_err_nx;
`endif

    // ------------------------------------------------------------------
    // Next-state, exposure value and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_exp_nx   = r_exp;
`ifdef CAMERA_CTRL_TIMEOUT_EN
        w_to_cnt_nx = r_to_cnt;
        w_err_nx    = r_err;
`endif

        case (r_state)
            S_IDLE: begin
                // Saturation is tested before stepping so the value never wraps.
                if (Exp_increase && !Exp_decrease && (r_exp < c_EXP_MAX)) begin
                    w_exp_nx = r_exp + 1'b1;
                end else if (Exp_decrease && !Exp_increase && (r_exp > c_EXP_MIN)) begin
                    w_exp_nx = r_exp - 1'b1;
                end
                if (Init) begin
                    w_state_nx = S_ARM;
`ifdef CAMERA_CTRL_TIMEOUT_EN
                    w_err_nx   = 1'b0;
`endif
                end
            end

            S_ARM: begin
                w_state_nx = S_EXPOSE;
`ifdef CAMERA_CTRL_TIMEOUT_EN
                w_to_cnt_nx = '0;
`endif
            end

            S_EXPOSE: begin
                // TF wins over the watchdog on the final EXPOSE cycle.
                if (TF) begin
                    w_state_nx = S_READOUT;
                    w_step_nx  = '0;
                end
`ifdef CAMERA_CTRL_TIMEOUT_EN
                else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nx = S_IDLE;
                    w_err_nx   = 1'b1;
                end else begin
                    w_to_cnt_nx = r_to_cnt + 1'b1;
                end
`endif
            end

            S_READOUT: begin
                if (r_step == c_STEP_LAST) begin
                    w_state_nx = S_IDLE;
                    w_step_nx  = '0;
                end else begin
                    w_step_nx  = r_step + 1'b1;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_step_nx  = '0;
            end
        endcase

        // Outputs are decoded from the upcoming state so that they appear
        // in the same cycle as the state they belong to, yet come from flops.
        w_start  = (w_state_nx == S_ARM);
        w_expose = (w_state_nx == S_ARM) || (w_state_nx == S_EXPOSE);
        w_erase  = (w_state_nx == S_IDLE);
        w_busy   = (w_state_nx != S_IDLE);
        w_nre1   = !((w_state_nx == S_READOUT) && (w_step_nx <  c_STEP_ROW2));
        w_nre2   = !((w_state_nx == S_READOUT) && (w_step_nx >= c_STEP_ROW2));
        w_adc    = (w_state_nx == S_READOUT) &&
                   ((w_step_nx == 3'd1) || (w_step_nx == 3'd4));
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_exp    <= c_EXP_RESET;
            r_start  <= 1'b0;
            r_erase  <= 1'b1;
            r_expose <= 1'b0;
            r_nre1   <= 1'b1;
            r_nre2   <= 1'b1;
            r_adc    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_step   <= w_step_nx;
            r_exp    <= w_exp_nx;
            r_start  <= w_start;
            r_erase  <= w_erase;
            r_expose <= w_expose;
            r_nre1   <= w_nre1;
            r_nre2   <= w_nre2;
            r_adc    <= w_adc;
            r_busy   <= w_busy;
        end
    end

`ifdef CAMERA_CTRL_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nx;
            r_err    <= w_err_nx;
        end
    end

    assign Err = r_err;
`endif

    assign Start   = r_start;
    assign Initial = r_exp;
    assign Erase   = r_erase;
    assign Expose  = r_expose;
    assign NRE_1   = r_nre1;
    assign NRE_2   = r_nre2;
    assign ADC     = r_adc;
    assign Busy    = r_busy;

endmodule
`default_nettype wire

// File: doc/camera_ctrl.md
Name: camera_ctrl

Overview:
- Exposure/readout controller and initiator for the exposure timer: sets the 5-bit `Initial`, pulses `Start`, waits for `TF`, then runs a fixed two-row readout.
- Sits between the user button inputs and the pixel array/ADC.
- Owns the exposure-time register, which the user adjusts with increase/decrease buttons while idle.

Parameters:
- EXP_WIDTH, 5, width of the exposure value and the `Initial` port.
- EXP_MIN, 2, lowest exposure value; decrement saturates here.
- EXP_MAX, 30, highest exposure value; increment saturates here.
- EXP_RESET, 16, exposure value loaded at reset.
- TO_CYCLES, 34, watchdog limit in EXPOSE (used only with the optional feature).

Ports:
- Clk  in  1  system clock; all activity on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- Init  in  1  request one exposure+readout cycle; level, sampled in IDLE only.
- Exp_increase  in  1  add 1 to the exposure value; sampled in IDLE only.
- Exp_decrease  in  1  subtract 1 from the exposure value; sampled in IDLE only.
- TF  in  1  timer-finished from the exposure timer.
- Start  out  1  one-cycle start pulse to the timer.
- Initial  out  EXP_WIDTH  exposure count to the timer.
- Erase  out  1  pixel erase, high while idle.
- Expose  out  1  pixel expose, high during ARM and EXPOSE.
- NRE_1  out  1  row-1 read enable, active-low.
- NRE_2  out  1  row-2 read enable, active-low.
- ADC  out  1  ADC sample strobe.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, Initial=EXP_RESET, Start=0, Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0, step counter 0.
- Reset mid-operation: all outputs return to these values at the next edge, regardless of state.
- All outputs are registered.
- States:
  - IDLE: Erase=1. If Init=1, go to ARM.
  - ARM: exactly one cycle. Start=1, Expose=1, Erase=0. Then go to EXPOSE.
  - EXPOSE: Start=0, Expose=1. On the first cycle TF=1, go to READOUT. TF is level-sensitive.
  - READOUT: Expose=0, Erase=0. Runs steps 0..5, then returns to IDLE with Erase=1.
    - Steps 0–2: NRE_1=0.
    - Steps 3–5: NRE_2=0.
    - Steps 1 and 4: ADC=1.
- Latency:
  - Init sampled high in IDLE → Start high on the next cycle.
  - TF sampled high in EXPOSE → NRE_1 low on the next cycle.
- TF is ignored in IDLE, ARM and READOUT. A stale TF held high from a previous run therefore cannot skip EXPOSE via ARM.
- Init is ignored outside IDLE. Init held high re-arms immediately after READOUT, giving back-to-back cycles.
- Exposure adjust, IDLE only:
  - Increase=1, Decrease=0: value+1, saturating at EXP_MAX.
  - Decrease=1, Increase=0: value−1, saturating at EXP_MIN.
  - Both high: no change.
  - One step per cycle while held.
  - If Init and an adjust arrive in the same IDLE cycle, the adjust is applied and the new value drives Initial from ARM onward.
- Initial is stable from ARM until the return to IDLE. Adjust inputs are ignored outside IDLE.
- Arithmetic: unsigned EXP_WIDTH bits. Saturation is checked before the add/subtract, so the value never wraps.

Optional Feature:
- Macro: CAMERA_CTRL_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in EXPOSE.
  - If TF has not arrived after TO_CYCLES cycles, go to IDLE without readout (NRE_1, NRE_2 and ADC never asserted).
  - Extra output port Err (1 bit) goes high and stays set until the next Init accepted in IDLE. Reset value of Err is 0.
- Disabled: no counter and no Err port; EXPOSE waits for TF indefinitely.

Test Plan:
- Reset, then Init=1 for 1 cycle; TF pulsed 16 cycles after Start → Start high exactly 1 cycle with Initial=16, Expose high 17 cycles, then NRE_1 low 3 cycles, NRE_2 low 3 cycles, ADC high at steps 1 and 4, Busy low after 6 readout cycles.
- IDLE: Exp_increase held 20 cycles → Initial saturates at 30. Exp_decrease held 40 cycles → 2. Both high → unchanged.
- During EXPOSE: toggle Exp_increase and Init → Initial and sequence unchanged.
- Hold TF=1 continuously, then Init → ARM lasts 1 cycle, EXPOSE exits on its first cycle, readout completes normally.
- Assert Reset at readout step 2 → next cycle all outputs at reset values, Initial=16.
- With CAMERA_CTRL_TIMEOUT_EN defined, Init with TF held 0 → after 34 EXPOSE cycles return to IDLE, Err=1, no NRE/ADC activity. Next Init → Err=0.
